// File: rtl/detector_jogada.sv
// detector_jogada: synchronises, debounces and validates the four player buttons, emitting one
// registered move code and strobe per physical press. Optional idle timeout: DETECTOR_TIMEOUT_EN.
module detector_jogada #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes,
  input  logic       habilita,
  output logic [3:0] jogada,
  output logic       tem_jogada,
  output logic       multipla,
  output logic       timeout,
  output logic [2:0] db_estado
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    ESPERA = 3'd0,
    FILTRA = 3'd1,
    VALIDA = 3'd2,
    SEGURA = 3'd3,
    SOLTA  = 3'd4
  } estado_t;

  estado_t          estado;
  logic [3:0]       botoes_p0;
  logic [3:0]       botoes_s;
  logic [3:0]       codigo;
  logic [CNT_W-1:0] cnt;

  function automatic logic eh_um_quente(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  // Synchroniser stage p0 -> botoes_s, then press/release debounce FSM
  always_ff @(posedge clock) begin
    if (!reset) begin
      botoes_p0  <= 4'b0000;
      botoes_s   <= 4'b0000;
      estado     <= ESPERA;
      codigo     <= 4'b0000;
      cnt        <= '0;
      jogada     <= 4'b0000;
      tem_jogada <= 1'b0;
      multipla   <= 1'b0;
    end else begin
      botoes_p0  <= botoes;
      botoes_s   <= botoes_p0;
      tem_jogada <= 1'b0;
      multipla   <= 1'b0;
      case (estado)
        ESPERA: begin
          if (habilita && botoes_s != 4'b0000) begin
            estado <= FILTRA;
            codigo <= botoes_s;
            cnt    <= '0;
          end
        end
        FILTRA: begin
          // A changed code is bounce; losing habilita abandons the press silently.
          if (botoes_s != codigo) begin
            estado <= ESPERA;
          end else if (!habilita) begin
            estado <= SEGURA;
          end else if (cnt == CNT_LAST) begin
            if (eh_um_quente(codigo)) begin
              estado <= VALIDA;
            end else begin
              multipla <= 1'b1;
              estado   <= SEGURA;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        VALIDA: begin
          jogada     <= codigo;
          tem_jogada <= 1'b1;
          estado     <= SEGURA;
        end
        SEGURA: begin
          if (botoes_s == 4'b0000) begin
            estado <= SOLTA;
            cnt    <= '0;
          end
        end
        SOLTA: begin
          if (botoes_s != 4'b0000) begin
            estado <= SEGURA;
          end else if (cnt == CNT_LAST) begin
            estado <= ESPERA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: estado <= ESPERA;
      endcase
    end
  end

  assign db_estado = estado;

`ifdef DETECTOR_TIMEOUT_EN
  localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [IDLE_W-1:0] idle_cnt;

  // Idle stage: a press starting on the same edge suppresses the timeout strobe
  always_ff @(posedge clock) begin
    if (!reset) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (estado != ESPERA || !habilita || botoes_s != 4'b0000) begin
        idle_cnt <= '0;
      end else if (idle_cnt == IDLE_LAST) begin
        idle_cnt <= '0;
        timeout  <= 1'b1;
      end else begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_detector_jogada.sv
// Table-driven bench for detector_jogada plus hand-written multi-cycle sequences
// (habilita drop while filtering, reset mid-press, release bounce, idle timeout).
module tb_detector_jogada;

  localparam int DEB = 4;
  localparam int TO  = 50;

  logic       clock    = 1'b0;
  logic       reset    = 1'b0;
  logic       habilita = 1'b0;
  logic [3:0] botoes   = 4'b0000;
  logic [3:0] jogada;
  logic       tem_jogada;
  logic       multipla;
  logic       timeout;
  logic [2:0] db_estado;

  int n_vec = 0;
  int n_err = 0;

  detector_jogada #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .botoes    (botoes),
    .habilita  (habilita),
    .jogada    (jogada),
    .tem_jogada(tem_jogada),
    .multipla  (multipla),
    .timeout   (timeout),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst_n;
    logic       hab;
    logic [3:0] b;
    int         reps;
    logic [3:0] e_jog;
    logic       e_tem;
    logic       e_mul;
    logic [2:0] e_est;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int r, input int h, input int b, input int n,
                     input int j, input int t, input int m, input int e);
    vec_t x;
    x.rst_n = 1'(r);
    x.hab   = 1'(h);
    x.b     = 4'(b);
    x.reps  = n;
    x.e_jog = 4'(j);
    x.e_tem = 1'(t);
    x.e_mul = 1'(m);
    x.e_est = 3'(e);
    tbl.push_back(x);
  endtask

  // Clean one-hot press held 10 cycles from an idle ESPERA, then released.
  task automatic add_press(input int b, input int j_old);
    add(1, 1, b, 2, j_old, 0, 0, 0);
    add(1, 1, b, 4, j_old, 0, 0, 1);
    add(1, 1, b, 1, j_old, 0, 0, 2);
    add(1, 1, b, 1, b,     1, 0, 3);
    add(1, 1, b, 2, b,     0, 0, 3);
    add(1, 1, 0, 2, b,     0, 0, 3);
    add(1, 1, 0, 4, b,     0, 0, 4);
    add(1, 1, 0, 2, b,     0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_est(input logic [2:0] target, input int bound, output bit saw_tem);
    int n;
    n = 0;
    saw_tem = 1'b0;
    while (db_estado !== target && n < bound) begin
      tick();
      n++;
      if (tem_jogada === 1'b1) saw_tem = 1'b1;
    end
  endtask

  task automatic wait_tem(input int bound, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (tem_jogada !== 1'b1 && n < bound);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  saw;
    logic exp_to;

    // Reset then idle
    add(0, 1, 0, 1, 0, 0, 0, 0);
    add(1, 1, 0, 10, 0, 0, 0, 0);
    // Clean press of button 0
    add_press(1, 0);
    // Bouncing 0100 then held
    add(1, 1, 4, 1, 1, 0, 0, 0);
    add(1, 1, 0, 1, 1, 0, 0, 0);
    add(1, 1, 4, 1, 1, 0, 0, 1);
    add(1, 1, 4, 1, 1, 0, 0, 0);
    add(1, 1, 4, 4, 1, 0, 0, 1);
    add(1, 1, 4, 1, 1, 0, 0, 2);
    add(1, 1, 4, 1, 4, 1, 0, 3);
    add(1, 1, 4, 3, 4, 0, 0, 3);
    add(1, 1, 0, 2, 4, 0, 0, 3);
    add(1, 1, 0, 4, 4, 0, 0, 4);
    add(1, 1, 0, 1, 4, 0, 0, 0);
    // Two buttons: multipla, jogada kept
    add(1, 1, 3, 2, 4, 0, 0, 0);
    add(1, 1, 3, 4, 4, 0, 0, 1);
    add(1, 1, 3, 1, 4, 0, 1, 3);
    add(1, 1, 3, 3, 4, 0, 0, 3);
    add(1, 1, 0, 2, 4, 0, 0, 3);
    add(1, 1, 0, 4, 4, 0, 0, 4);
    add(1, 1, 0, 2, 4, 0, 0, 0);
    add_press(2, 4);
    // habilita low: press ignored; then accepted once enabled
    add(1, 0, 8, 10, 2, 0, 0, 0);
    add(1, 0, 0, 3, 2, 0, 0, 0);
    add_press(8, 2);

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        reset    = tbl[i].rst_n;
        habilita = tbl[i].hab;
        botoes   = tbl[i].b;
        tick();
        n_vec++;
        if ({jogada, tem_jogada, multipla, timeout, db_estado} !==
            {tbl[i].e_jog, tbl[i].e_tem, tbl[i].e_mul, 1'b0, tbl[i].e_est}) begin
          n_err++;
          $display("FAIL vec%0d.%0d: jogada=%b tem=%b mult=%b to=%b est=%0d, expected jogada=%b tem=%b mult=%b to=0 est=%0d",
                   i, r, jogada, tem_jogada, multipla, timeout, db_estado,
                   tbl[i].e_jog, tbl[i].e_tem, tbl[i].e_mul, tbl[i].e_est);
        end
      end
    end

    // habilita dropped while filtering -> SEGURA, no strobe
    botoes = 4'b0001; habilita = 1'b1;
    tick(); tick(); tick();
    chk("filtra_entry", 32'(db_estado), 32'd1);
    habilita = 1'b0;
    tick();
    chk("hab_drop_segura", 32'(db_estado), 32'd3);
    chk("hab_drop_no_tem", 32'(tem_jogada), 32'd0);
    tick(); tick();
    botoes = 4'b0000; habilita = 1'b1;
    wait_est(3'd0, 20, saw);
    chk("hab_drop_back_espera", 32'(db_estado), 32'd0);
    chk("hab_drop_tem_seen", 32'(saw), 32'd0);
    chk("hab_drop_jogada", 32'(jogada), 32'd8);

    // Reset mid-press; button still held is a fresh press
    botoes = 4'b0100;
    tick(); tick(); tick(); tick();
    reset = 1'b0;
    tick();
    chk("midreset_estado", 32'(db_estado), 32'd0);
    chk("midreset_jogada", 32'(jogada), 32'd0);
    chk("midreset_tem", 32'(tem_jogada), 32'd0);
    reset = 1'b1;
    wait_tem(20, n);
    chk("fresh_press_latency", 32'(n), 32'd8);
    chk("fresh_press_jogada", 32'(jogada), 32'd4);
    botoes = 4'b0000;
    wait_est(3'd0, 20, saw);
    chk("fresh_press_release", 32'(db_estado), 32'd0);

    // Release bounce: SOLTA -> SEGURA, no second strobe
    botoes = 4'b0010;
    wait_tem(20, n);
    chk("bounce_press_latency", 32'(n), 32'd8);
    tick(); tick();
    botoes = 4'b0000;
    tick(); tick(); tick();
    chk("solta_entry", 32'(db_estado), 32'd4);
    botoes = 4'b0010;
    tick();
    botoes = 4'b0000;
    tick();
    chk("solta_counting", 32'(db_estado), 32'd4);
    tick();
    chk("release_bounce_segura", 32'(db_estado), 32'd3);
    wait_est(3'd0, 20, saw);
    chk("release_bounce_espera", 32'(db_estado), 32'd0);
    chk("release_bounce_no_tem", 32'(saw), 32'd0);
    chk("release_bounce_jogada", 32'(jogada), 32'd2);

    // Idle timeout pulses (tied low without the option)
    reset = 1'b0; habilita = 1'b1; botoes = 4'b0000;
    tick();
    reset = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      tick();
`ifdef DETECTOR_TIMEOUT_EN
      exp_to = (k == TO) || (k == 2 * TO);
`else
      exp_to = 1'b0;
`endif
      if (timeout !== exp_to) begin
        n_vec++;
        n_err++;
        $display("FAIL idle_timeout_cycle%0d: got %b, expected %b", k, timeout, exp_to);
      end else begin
        n_vec++;
      end
    end

    // Press at cycle 40 restarts the idle count from the return to ESPERA
    reset = 1'b0;
    tick();
    reset = 1'b1;
    saw = 1'b0;
    for (int k = 1; k <= 39; k++) begin
      tick();
      if (timeout === 1'b1) saw = 1'b1;
    end
    botoes = 4'b0001;
    for (int k = 40; k <= 49; k++) begin
      tick();
      if (timeout === 1'b1) saw = 1'b1;
    end
    chk("press_before_timeout", 32'(saw), 32'd0);
    botoes = 4'b0000;
    wait_est(3'd0, 30, saw);
    chk("press40_back_espera", 32'(db_estado), 32'd0);
    n = 0;
    do begin
      tick();
      n++;
    end while (timeout !== 1'b1 && n < 60);
`ifdef DETECTOR_TIMEOUT_EN
    chk("timeout_after_return", 32'(n), 32'(TO));
`else
    chk("timeout_never", 32'(n), 32'd60);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
